// File: rtl/core_mrpnwp_pkg.sv
// core_mrpnwp_pkg: default widths, address-split helpers and read pipeline entry type
package core_mrpnwp_pkg;
  localparam int WIDTH_D   = 32;
  localparam int BITADDR_D = 13;
  localparam int NUMVBNK_D = 8;
  localparam int BITVBNK_D = 3;
  localparam int BITVROW_D = 10;
  localparam int BITPADR_D = 13;

  typedef struct packed {
    logic                 vld;
    logic [BITVBNK_D-1:0] bank;
    logic [BITPADR_D-1:0] padr;
  } pipe_entry_t;

  function automatic logic [BITVBNK_D-1:0] bank_of(input logic [BITADDR_D-1:0] addr);
    return addr[BITVBNK_D-1:0];
  endfunction

  function automatic logic [BITVROW_D-1:0] row_of(input logic [BITADDR_D-1:0] addr);
    return addr[BITADDR_D-1:BITVBNK_D];
  endfunction
endpackage

// File: rtl/core_mrpnwp_rd_pipe.sv
// core_mrpnwp_rd_pipe: per-port valid/bank/padr shift pipeline matching bank read latency
module core_mrpnwp_rd_pipe
  import core_mrpnwp_pkg::*;
#(
  parameter int SRAM_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pipe_entry_t ent_in,
  output pipe_entry_t ent_out
);
  pipe_entry_t stg [SRAM_DELAY];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < SRAM_DELAY; s++) stg[s] <= '0;
    end else begin
      stg[0] <= ent_in;
      for (int s = 1; s < SRAM_DELAY; s++) stg[s] <= stg[s-1];
    end

  assign ent_out = stg[SRAM_DELAY-1];
endmodule

// File: rtl/core_mrpnwp_1r1w_resp.sv
// core_mrpnwp_1r1w_resp: maps port requests onto 1R1W banks, arbitrates per bank
// and returns read data aligned with the bank read latency.
module core_mrpnwp_1r1w_resp
  import core_mrpnwp_pkg::*;
#(
  parameter int WIDTH      = WIDTH_D,
  parameter int NUMRDPT    = 2,
  parameter int NUMWRPT    = 3,
  parameter int BITADDR    = BITADDR_D,
  parameter int NUMVBNK    = NUMVBNK_D,
  parameter int BITVBNK    = BITVBNK_D,
  parameter int BITVROW    = BITVROW_D,
  parameter int BITPADR    = BITPADR_D,
  parameter int SRAM_DELAY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUMRDPT-1:0]         pread,
  input  logic [NUMRDPT*BITADDR-1:0] pradr,
  input  logic [NUMWRPT-1:0]         pwrite,
  input  logic [NUMWRPT*BITADDR-1:0] pwadr,
  input  logic [NUMWRPT*WIDTH-1:0]   pdin,
  output logic [NUMVBNK-1:0]         t1_readA,
  output logic [NUMVBNK*BITVROW-1:0] t1_addrA,
  input  logic [NUMVBNK*WIDTH-1:0]   t1_doutA,
  output logic [NUMVBNK-1:0]         t1_writeB,
  output logic [NUMVBNK*BITVROW-1:0] t1_addrB,
  output logic [NUMVBNK*WIDTH-1:0]   t1_dinB,
  output logic [NUMRDPT*WIDTH-1:0]   t1_doutB,
  output logic [NUMRDPT-1:0]         vread_vld_bus,
  output logic [NUMRDPT*BITPADR-1:0] vread_padr_bus,
  output logic [NUMRDPT-1:0]         rd_conflict,
  output logic [NUMWRPT-1:0]         wr_conflict
);
  logic [NUMVBNK-1:0] rd_bank, wr_bank;
  logic [NUMRDPT-1:0] rd_grant;
  logic [NUMWRPT-1:0] wr_grant;

  // Ascending scan: the first (lowest) read port to claim a bank keeps it.
  always_comb begin
    logic [BITVBNK-1:0] bk;
    rd_bank  = '0;
    rd_grant = '0;
    t1_addrA = '0;
    for (int i = 0; i < NUMRDPT; i++) begin
      bk = bank_of(pradr[i*BITADDR+:BITADDR]);
      if (rst_n && pread[i] && !rd_bank[bk]) begin
        rd_bank[bk]                   = 1'b1;
        rd_grant[i]                   = 1'b1;
        t1_addrA[bk*BITVROW+:BITVROW] = row_of(pradr[i*BITADDR+:BITADDR]);
      end
    end
  end

  // Descending scan: the last (highest) write port has priority.
  always_comb begin
    logic [BITVBNK-1:0] bk;
    wr_bank  = '0;
    wr_grant = '0;
    t1_addrB = '0;
    t1_dinB  = '0;
    for (int i = NUMWRPT-1; i >= 0; i--) begin
      bk = bank_of(pwadr[i*BITADDR+:BITADDR]);
      if (rst_n && pwrite[i] && !wr_bank[bk]) begin
        wr_bank[bk]                   = 1'b1;
        wr_grant[i]                   = 1'b1;
        t1_addrB[bk*BITVROW+:BITVROW] = row_of(pwadr[i*BITADDR+:BITADDR]);
        t1_dinB[bk*WIDTH+:WIDTH]      = pdin[i*WIDTH+:WIDTH];
      end
    end
  end

  assign t1_readA  = rd_bank;
  assign t1_writeB = wr_bank;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_conflict <= '0;
      wr_conflict <= '0;
    end else begin
      rd_conflict <= pread & ~rd_grant;
      wr_conflict <= pwrite & ~wr_grant;
    end

  for (genvar i = 0; i < NUMRDPT; i++) begin : g_rd
    pipe_entry_t ent_in, ent_out;
    assign ent_in = rd_grant[i] ? '{vld: 1'b1, bank: bank_of(pradr[i*BITADDR+:BITADDR]),
                                    padr: pradr[i*BITADDR+:BITADDR]} : '0;
    core_mrpnwp_rd_pipe #(.SRAM_DELAY(SRAM_DELAY)) u_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .ent_in  (ent_in),
      .ent_out (ent_out)
    );
    assign vread_vld_bus[i]                  = ent_out.vld;
    assign vread_padr_bus[i*BITPADR+:BITPADR] = ent_out.padr;
    assign t1_doutB[i*WIDTH+:WIDTH] = ent_out.vld ? t1_doutA[ent_out.bank*WIDTH+:WIDTH] : '0;
  end
endmodule

// File: tb/tb_core_mrpnwp_1r1w_resp.sv
// tb_core_mrpnwp_1r1w_resp: directed vectors with hand-computed expectations
module tb_core_mrpnwp_1r1w_resp;
  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    pread;
  logic [25:0]   pradr;
  logic [2:0]    pwrite;
  logic [38:0]   pwadr;
  logic [95:0]   pdin;
  logic [7:0]    t1_readA;
  logic [79:0]   t1_addrA;
  logic [255:0]  t1_doutA;
  logic [7:0]    t1_writeB;
  logic [79:0]   t1_addrB;
  logic [255:0]  t1_dinB;
  logic [63:0]   t1_doutB;
  logic [1:0]    vread_vld_bus;
  logic [25:0]   vread_padr_bus;
  logic [1:0]    rd_conflict;
  logic [2:0]    wr_conflict;
  int            n_cmp = 0;
  int            n_bad = 0;

  core_mrpnwp_1r1w_resp dut (
    .clk(clk), .rst_n(rst_n), .pread(pread), .pradr(pradr), .pwrite(pwrite),
    .pwadr(pwadr), .pdin(pdin), .t1_readA(t1_readA), .t1_addrA(t1_addrA),
    .t1_doutA(t1_doutA), .t1_writeB(t1_writeB), .t1_addrB(t1_addrB),
    .t1_dinB(t1_dinB), .t1_doutB(t1_doutB), .vread_vld_bus(vread_vld_bus),
    .vread_padr_bus(vread_padr_bus), .rd_conflict(rd_conflict), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pread = '0; pradr = '0; pwrite = '0; pwadr = '0; pdin = '0;
  endtask

  initial begin
    for (int b = 0; b < 8; b++) t1_doutA[b*32+:32] = 32'hD000_0000 + b;
    idle();
    rst_n = 1'b0;
    pread = 2'b11; pwrite = 3'b111;
    #1;
    check("rst_readA", t1_readA, 0);
    check("rst_writeB", t1_writeB, 0);
    tick();
    check("rst_vld", vread_vld_bus, 0);
    check("rst_rdc", rd_conflict, 0);
    check("rst_wrc", wr_conflict, 0);
    check("rst_doutB", t1_doutB, 0);
    idle();
    #2 rst_n = 1'b1;
    tick();

    // single read 0x0A5 -> bank 5, row 0x14
    pread = 2'b01; pradr[12:0] = 13'h0A5;
    #1;
    check("sr_readA", t1_readA, 8'h20);
    check("sr_addrA5", t1_addrA[50+:10], 10'h014);
    tick(); idle();
    check("sr_vld_c1", vread_vld_bus, 0);
    check("sr_rdc_c1", rd_conflict, 0);
    tick();
    check("sr_vld_c2", vread_vld_bus, 2'b01);
    check("sr_padr_c2", vread_padr_bus[12:0], 13'h0A5);
    check("sr_dout_c2", t1_doutB[31:0], 32'hD000_0005);
    check("sr_dout1_c2", t1_doutB[63:32], 0);
    tick();
    check("sr_vld_c3", vread_vld_bus, 0);

    // read collision on bank 3
    pread = 2'b11; pradr = {13'h00B, 13'h003};
    #1;
    check("rc_readA", t1_readA, 8'h08);
    check("rc_addrA3", t1_addrA[30+:10], 10'h000);
    tick(); idle();
    check("rc_rdc_c1", rd_conflict, 2'b10);
    tick();
    check("rc_vld_c2", vread_vld_bus, 2'b01);
    check("rc_padr_c2", vread_padr_bus[12:0], 13'h003);
    check("rc_rdc_c2", rd_conflict, 0);

    // write collision on bank 1, ports 0 and 2
    pwrite = 3'b101; pwadr = {13'h009, 13'h000, 13'h001};
    pdin = {32'h33, 32'h0, 32'h11};
    #1;
    check("wc_writeB", t1_writeB, 8'h02);
    check("wc_dinB1", t1_dinB[32+:32], 32'h33);
    check("wc_addrB1", t1_addrB[10+:10], 10'h001);
    tick(); idle();
    check("wc_wrc_c1", wr_conflict, 3'b001);
    tick();
    check("wc_wrc_c2", wr_conflict, 0);

    // back-to-back reads to banks 0..7 on port 0
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c < 8) begin
        pread = 2'b01; pradr[12:0] = 13'((c << 3) | c);
        #1;
        check("bb_readA", t1_readA, 64'(1) << c);
      end
      if (c >= 2) begin
        check("bb_vld", vread_vld_bus, 2'b01);
        check("bb_padr", vread_padr_bus[12:0], 13'(((c-2) << 3) | (c-2)));
        check("bb_dout", t1_doutB[31:0], 32'hD000_0000 + (c-2));
      end
      tick();
    end
    idle();
    check("bb_vld_end", vread_vld_bus, 0);

    // same-bank read and write
    pread = 2'b01; pradr[12:0] = 13'h010; pwrite = 3'b001; pwadr[12:0] = 13'h010;
    #1;
    check("rw_readA", t1_readA, 8'h01);
    check("rw_writeB", t1_writeB, 8'h01);
    tick(); idle();
    check("rw_rdc", rd_conflict, 0);
    check("rw_wrc", wr_conflict, 0);
    tick(); tick();

    // reset mid-flight
    pread = 2'b01; pradr[12:0] = 13'h0A5;
    tick(); idle();
    rst_n = 1'b0;
    #1;
    check("rm_vld_rst", vread_vld_bus, 0);
    tick();
    check("rm_vld_c2", vread_vld_bus, 0);
    #2 rst_n = 1'b1;
    tick();
    check("rm_vld_c3", vread_vld_bus, 0);
    pread = 2'b01; pradr[12:0] = 13'h0C6;
    tick(); idle();
    check("rm_new_c1", vread_vld_bus, 0);
    tick();
    check("rm_new_vld", vread_vld_bus, 2'b01);
    check("rm_new_padr", vread_padr_bus[12:0], 13'h0C6);
    check("rm_new_dout", t1_doutB[31:0], 32'hD000_0006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/core_mrpnwp_1r1w_resp.md
Name: core_mrpnwp_1r1w_resp

Overview:
- Physical-side responder for the multi-read/multi-write 1R1W core wrapper.
- Accepts per-port physical read/write strobes and addresses from the core wrapper.
- Maps each address to one of NUMVBNK 1R1W SRAM banks, drives the bank ports, and tracks in-flight reads through an SRAM_DELAY-deep pipeline.
- Returns per-port read data, read-valid and physical address buses to the wrapper, and flags same-cycle bank conflicts.

Parameters:
- WIDTH, 32, data width per port.
- NUMRDPT, 2, number of read ports.
- NUMWRPT, 3, number of write ports.
- BITADDR, 13, logical address width.
- NUMVBNK, 8, number of SRAM banks.
- BITVBNK, 3, bank-select width (log2 NUMVBNK).
- BITVROW, 10, row width (BITADDR-BITVBNK).
- BITPADR, 13, physical address width returned to the wrapper.
- SRAM_DELAY, 2, bank read latency in cycles (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pread  in  NUMRDPT  read strobe per port.
- pradr  in  NUMRDPT*BITADDR  read address per port.
- pwrite  in  NUMWRPT  write strobe per port.
- pwadr  in  NUMWRPT*BITADDR  write address per port.
- pdin  in  NUMWRPT*WIDTH  write data per port.
- t1_readA  out  NUMVBNK  bank read enable.
- t1_addrA  out  NUMVBNK*BITVROW  bank read row.
- t1_doutA  in  NUMVBNK*WIDTH  bank read data, valid SRAM_DELAY cycles after t1_readA.
- t1_writeB  out  NUMVBNK  bank write enable.
- t1_addrB  out  NUMVBNK*BITVROW  bank write row.
- t1_dinB  out  NUMVBNK*WIDTH  bank write data.
- t1_doutB  out  NUMRDPT*WIDTH  per-port read data to the wrapper.
- vread_vld_bus  out  NUMRDPT  per-port read valid.
- vread_padr_bus  out  NUMRDPT*BITPADR  per-port physical address.
- rd_conflict  out  NUMRDPT  read dropped due to a bank collision.
- wr_conflict  out  NUMWRPT  write dropped due to a bank collision.

Behaviour:
- Address split: bank = addr[BITVBNK-1:0]; row = addr[BITADDR-1:BITVBNK]; padr = addr, zero-extended or truncated to BITPADR.
- Read issue, cycle 0:
  - For each bank, the lowest-index read port with pread set and a matching bank wins.
  - Winner drives t1_readA[bank]=1 and t1_addrA[bank]=row in the same cycle, combinationally from the inputs.
  - Losing ports get no read. rd_conflict[i] pulses for 1 cycle, registered, at cycle 1.
- Read return:
  - Per port, a pipeline of SRAM_DELAY stages of {vld, bank, padr}.
  - At cycle SRAM_DELAY, vread_vld_bus[i], vread_padr_bus[i] and t1_doutB[i] = t1_doutA[bank] are valid together.
  - All three outputs are registered pipeline outputs. Data is muxed from the stored bank index.
- Write issue, cycle 0:
  - For each bank, the highest-index write port wins; last writer has priority.
  - Winner drives t1_writeB, t1_addrB and t1_dinB combinationally.
  - Losers get wr_conflict pulsed at cycle 1.
- Same-cycle read and write to the same bank: both are issued (1R1W bank). Same-row data follows the SRAM's read-old semantics; the responder neither forwards nor stalls.
- Invalid stages: t1_doutB holds 0, vread_padr_bus holds 0, vread_vld_bus holds 0.
- Reset:
  - rst_n low clears all pipeline stages and the conflict flags immediately.
  - All registered outputs go to 0. t1_* strobes are forced to 0 while rst_n is low.
  - Reads in flight at reset are discarded, never returned.
  - After deassertion, the first request is accepted on the first rising edge.
- Throughput: one request per port per cycle, back-to-back, with no bubbles.

Decomposition:
- Package core_mrpnwp_pkg holds:
  - address-split helper functions (bank_of, row_of);
  - localparams for default widths;
  - a struct for a pipeline entry {vld, bank, padr}.
- Sub-module core_mrpnwp_rd_pipe: one-port, SRAM_DELAY-deep valid/bank/padr shift pipeline with async clear. It is instantiated NUMRDPT times.
- Bank arbitration stays in the top as generate loops.

Test Plan:
- Single read: pread=01, pradr[0]=0x0A5 → t1_readA[5]=1, t1_addrA[5]=0x014 at cycle 0. At cycle 2: vread_vld_bus=01, vread_padr_bus[0]=0x0A5, t1_doutB[0]=t1_doutA[5].
- Read collision: both ports read bank 3 (0x003, 0x00B) → only port 0 is issued. rd_conflict=10 at cycle 1. vread_vld_bus=01 at cycle 2.
- Write collision: ports 0 and 2 write bank 1, data 0x11/0x33 → t1_dinB[1]=0x33. wr_conflict=001 at cycle 1.
- Back-to-back: reads every cycle to banks 0..7 for 8 cycles → vread_vld_bus stays 1 for 8 cycles starting at cycle 2. padr order is preserved.
- Same-bank read+write: read 0x010 and write 0x010 in the same cycle → both strobes asserted and no conflict flags raised.
- Reset mid-flight: issue read, assert rst_n low at cycle 1 → vread_vld_bus is 0 at cycle 2 and stays 0. After release, a new read returns after exactly SRAM_DELAY cycles.
